// File: rtl/beta_pkg.sv
// beta_pkg: shared types and constants for the beta fetch unit.
//   XLEN              - machine word width
//   BOOT_ADDR_DEFAULT - default reset PC
//   fetch_state_e     - fetch FSM state encoding
//   ibuf_entry_t      - one instruction-buffer entry {pc, instr}
package beta_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] BOOT_ADDR_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HALT = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } ibuf_entry_t;

endpackage

// File: rtl/beta_ibuf.sv
// beta_ibuf: two-entry instruction buffer (circular, registered head).
// Ports:
//   clk_i, rstn_i     - clock, asynchronous active-low reset
//   push_i/push_data_i- write one entry
//   pop_i             - remove the head entry
//   flush_i           - discard all entries (wins over push/pop)
//   head_o            - current head entry (undefined when empty)
//   full_o, empty_o   - occupancy flags
//   count_o           - number of valid entries (0..2)
module beta_ibuf
  import beta_pkg::*;
(
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        push_i,
  input  ibuf_entry_t push_data_i,
  input  logic        pop_i,
  input  logic        flush_i,
  output ibuf_entry_t head_o,
  output logic        full_o,
  output logic        empty_o,
  output logic [1:0]  count_o
);

  ibuf_entry_t mem_q [0:1];
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic [1:0]  count_q, count_d;
  logic        do_pop, do_push;

  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A push into a full buffer is accepted when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (do_pop)  rd_ptr_d = ~rd_ptr_q;
      if (do_push) wr_ptr_d = ~wr_ptr_q;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage carries data only; validity is tracked by count_q.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/beta_fetch.sv
// beta_fetch: instruction fetch unit with a 2-entry instruction buffer.
// Optional feature macro: BETA_FETCH_MISALIGN_CHECK_EN
//   defined   - misaligned redirect targets pulse fetch_misaligned_o and halt
//   undefined - redirect targets are word-aligned by clearing bits [1:0]
// Ports:
//   clk_i, rstn_i                      - clock, asynchronous active-low reset
//   imem_req_o/imem_addr_o/imem_gnt_i  - instruction memory address phase
//   imem_rvalid_i/imem_rdata_i         - instruction memory response phase
//   instr_o/pc_o/instr_valid_o         - buffer head towards the decoder
//   instr_ready_i                      - decoder accept (pop on valid & ready)
//   redirect_i/redirect_pc_i           - branch/jump/exception redirect
//   fetch_misaligned_o                 - one-cycle misaligned-target pulse
module beta_fetch
  import beta_pkg::*;
#(
  parameter logic [XLEN-1:0] BOOT_ADDR  = BOOT_ADDR_DEFAULT,
  parameter int              IBUF_DEPTH = 2
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic            instr_valid_o,
  input  logic            instr_ready_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            fetch_misaligned_o
);

  localparam logic [2:0] IBUF_CAP = 3'(IBUF_DEPTH);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic            discard_q, discard_d;
  logic            mis_d;
  logic            req;
  logic            push, pop, flush;
  logic            can_issue;
  logic            redir_bad;
  logic [XLEN-1:0] redir_target;
  ibuf_entry_t     push_entry, head;
  logic            ibuf_full, ibuf_empty;
  logic [1:0]      ibuf_count;

`ifdef BETA_FETCH_MISALIGN_CHECK_EN
  logic mis_q;
  assign redir_bad          = (redirect_pc_i[1:0] != 2'b00);
  assign redir_target       = redirect_pc_i;
  assign fetch_misaligned_o = mis_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) mis_q <= 1'b0;
    else         mis_q <= mis_d;
  end
`else
  assign redir_bad          = 1'b0;
  assign redir_target       = redirect_pc_i & ~XLEN'(3);
  assign fetch_misaligned_o = 1'b0;
`endif

  // In REQ the only request that can still be in flight is a discarded one,
  // so discard_q is the outstanding count seen from this state.
  assign can_issue = !discard_q && !ibuf_full &&
                     (({1'b0, ibuf_count} + {2'b00, discard_q}) < IBUF_CAP);

  assign push_entry = '{pc: fetch_pc_q, instr: imem_rdata_i};

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fetch_pc_d = fetch_pc_q;
    discard_d  = discard_q;
    mis_d      = 1'b0;
    req        = 1'b0;
    push       = 1'b0;
    flush      = 1'b0;

    // A dropped response closes out the stale request whatever the state.
    if (discard_q && imem_rvalid_i) discard_d = 1'b0;

    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        req = can_issue;
        if (req && imem_gnt_i) begin
          pc_d       = pc_q + XLEN'(4);
          fetch_pc_d = pc_q;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid_i) begin
          push    = 1'b1;
          state_d = REQ;
        end
      end
      HALT: state_d = HALT;
      default: state_d = IDLE;
    endcase

    if (redirect_i) begin
      flush = 1'b1;
      push  = 1'b0;
      // A request still owed a response after this cycle must have it dropped.
      if (((state_q == WAIT) && !imem_rvalid_i) || (req && imem_gnt_i))
        discard_d = 1'b1;
      if (redir_bad) begin
        mis_d   = 1'b1;
        pc_d    = pc_q;
        state_d = HALT;
      end else begin
        pc_d    = redir_target;
        state_d = REQ;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= IDLE;
      pc_q      <= BOOT_ADDR;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      discard_q <= discard_d;
    end
  end

  always_ff @(posedge clk_i) begin
    fetch_pc_q <= fetch_pc_d;
  end

  assign imem_req_o    = req;
  assign imem_addr_o   = req ? pc_q : '0;
  assign instr_valid_o = !ibuf_empty && (state_q != HALT);
  assign instr_o       = instr_valid_o ? head.instr : '0;
  assign pc_o          = instr_valid_o ? head.pc : '0;
  assign pop           = instr_valid_o && instr_ready_i;

  beta_ibuf u_ibuf (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .flush_i     (flush),
    .head_o      (head),
    .full_o      (ibuf_full),
    .empty_o     (ibuf_empty),
    .count_o     (ibuf_count)
  );

endmodule

// File: tb/tb_beta_fetch.sv
module tb_beta_fetch;

  logic        clk = 1'b0;
  logic        rstn;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] instr, pc;
  logic        instr_valid, instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        misaligned;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  beta_fetch dut (
    .clk_i              (clk),
    .rstn_i             (rstn),
    .imem_req_o         (imem_req),
    .imem_addr_o        (imem_addr),
    .imem_gnt_i         (imem_gnt),
    .imem_rvalid_i      (imem_rvalid),
    .imem_rdata_i       (imem_rdata),
    .instr_o            (instr),
    .pc_o               (pc),
    .instr_valid_o      (instr_valid),
    .instr_ready_i      (instr_ready),
    .redirect_i         (redirect),
    .redirect_pc_i      (redirect_pc),
    .fetch_misaligned_o (misaligned)
  );

  typedef struct {
    logic        rstn, gnt, rvalid;
    logic [31:0] rdata;
    logic        ready, redir;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr, e_pc;
    logic        e_mis;
  } vec_t;

  vec_t vecs[$];

  localparam logic [31:0] A0 = 32'h1111_0000, A1 = 32'h1111_0004;
  localparam logic [31:0] A2 = 32'h1111_0008, A3 = 32'h1111_000C;
  localparam logic [31:0] B0 = 32'h2222_0100, C0 = 32'h3333_FFFC;
  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

  function automatic void add(input logic rs, gn, rv, input logic [31:0] rd,
                              input logic rdy, rdr, input logic [31:0] rpc,
                              input logic ereq, input logic [31:0] eaddr,
                              input logic evld, input logic [31:0] einstr, epc,
                              input logic emis);
    vec_t v;
    v.rstn = rs; v.gnt = gn; v.rvalid = rv; v.rdata = rd; v.ready = rdy;
    v.redir = rdr; v.rpc = rpc; v.e_req = ereq; v.e_addr = eaddr;
    v.e_valid = evld; v.e_instr = einstr; v.e_pc = epc; v.e_mis = emis;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (step %0d): got %h expected %h", name, idx, act, exp);
    end
  endtask

  initial begin
    int got;
    logic [31:0] exp_pc;
    logic pend;
    logic [31:0] pend_addr;

    rstn = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    instr_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;

    //   rstn gnt rv rdata ready redir rpc | req addr valid instr pc mis
    add(0, 0, 0, 32'h0, 0, 0, 32'h0,   0, 32'h0, 0, 32'h0, 32'h0, 0);
    add(0, 1, 1, JUNK,  1, 0, 32'h0,   0, 32'h0, 0, 32'h0, 32'h0, 0);
    add(1, 1, 0, 32'h0, 0, 0, 32'h0,   0, 32'h0, 0, 32'h0, 32'h0, 0); // IDLE
    add(1, 1, 0, 32'h0, 0, 0, 32'h0,   1, 32'h0, 0, 32'h0, 32'h0, 0); // req 0x0
    add(1, 0, 1, A0,    0, 0, 32'h0,   0, 32'h0, 0, 32'h0, 32'h0, 0); // WAIT
    add(1, 1, 0, 32'h0, 0, 0, 32'h0,   1, 32'h4, 1, A0, 32'h0, 0);    // first valid
    add(1, 0, 1, A1,    0, 0, 32'h0,   0, 32'h0, 1, A0, 32'h0, 0);
    add(1, 1, 0, 32'h0, 0, 0, 32'h0,   0, 32'h0, 1, A0, 32'h0, 0);    // full, no req
    add(1, 1, 0, 32'h0, 1, 0, 32'h0,   0, 32'h0, 1, A0, 32'h0, 0);    // single pop
    add(1, 1, 0, 32'h0, 0, 0, 32'h0,   1, 32'h8, 1, A1, 32'h4, 0);    // one new req
    add(1, 0, 1, A2,    1, 0, 32'h0,   0, 32'h0, 1, A1, 32'h4, 0);    // push+pop
    add(1, 0, 0, 32'h0, 0, 0, 32'h0,   1, 32'hC, 1, A2, 32'h8, 0);    // no grant
    add(1, 1, 0, 32'h0, 0, 0, 32'h0,   1, 32'hC, 1, A2, 32'h8, 0);
    add(1, 0, 1, A3,    0, 0, 32'h0,   0, 32'h0, 1, A2, 32'h8, 0);
    add(1, 0, 0, 32'h0, 1, 0, 32'h0,   0, 32'h0, 1, A2, 32'h8, 0);
    add(1, 1, 0, 32'h0, 0, 0, 32'h0,   1, 32'h10, 1, A3, 32'hC, 0);
    add(1, 0, 0, 32'h0, 0, 1, 32'h100, 0, 32'h0, 1, A3, 32'hC, 0);    // redirect in WAIT
    add(1, 1, 1, JUNK,  0, 0, 32'h0,   0, 32'h0, 0, 32'h0, 32'h0, 0); // stale rvalid
    add(1, 1, 0, 32'h0, 0, 0, 32'h0,   1, 32'h100, 0, 32'h0, 32'h0, 0);
    add(1, 0, 1, B0,    0, 0, 32'h0,   0, 32'h0, 0, 32'h0, 32'h0, 0);
    add(1, 1, 0, 32'h0, 1, 1, 32'h102, 1, 32'h104, 1, B0, 32'h100, 0); // granted in redirect
`ifdef BETA_FETCH_MISALIGN_CHECK_EN
    add(1, 1, 1, JUNK,  0, 0, 32'h0,   0, 32'h0, 0, 32'h0, 32'h0, 1); // HALT, pulse
    add(1, 1, 0, 32'h0, 0, 1, 32'h200, 0, 32'h0, 0, 32'h0, 32'h0, 0);
    add(1, 0, 0, 32'h0, 0, 1, 32'hFFFF_FFFC, 1, 32'h200, 0, 32'h0, 32'h0, 0);
`else
    add(1, 1, 1, JUNK,  0, 0, 32'h0,   0, 32'h0, 0, 32'h0, 32'h0, 0); // stale dropped
    add(1, 0, 0, 32'h0, 0, 1, 32'hFFFF_FFFC, 1, 32'h100, 0, 32'h0, 32'h0, 0);
`endif
    add(1, 1, 0, 32'h0, 0, 0, 32'h0,   1, 32'hFFFF_FFFC, 0, 32'h0, 32'h0, 0);
    add(1, 0, 1, C0,    0, 0, 32'h0,   0, 32'h0, 0, 32'h0, 32'h0, 0);
    add(1, 1, 0, 32'h0, 0, 0, 32'h0,   1, 32'h0, 1, C0, 32'hFFFF_FFFC, 0); // wrapped
    add(0, 0, 0, 32'h0, 0, 0, 32'h0,   0, 32'h0, 0, 32'h0, 32'h0, 0); // reset in WAIT
    add(1, 0, 1, JUNK,  0, 0, 32'h0,   0, 32'h0, 0, 32'h0, 32'h0, 0); // IDLE
    add(1, 0, 1, JUNK,  0, 0, 32'h0,   1, 32'h0, 0, 32'h0, 32'h0, 0); // orphan rvalid
    add(1, 0, 0, 32'h0, 0, 0, 32'h0,   1, 32'h0, 0, 32'h0, 32'h0, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      rstn = vecs[i].rstn; imem_gnt = vecs[i].gnt; imem_rvalid = vecs[i].rvalid;
      imem_rdata = vecs[i].rdata; instr_ready = vecs[i].ready;
      redirect = vecs[i].redir; redirect_pc = vecs[i].rpc;
      #1;
      chk("imem_req",    i, {31'b0, imem_req},    {31'b0, vecs[i].e_req});
      chk("imem_addr",   i, imem_addr,            vecs[i].e_addr);
      chk("instr_valid", i, {31'b0, instr_valid}, {31'b0, vecs[i].e_valid});
      chk("instr",       i, instr,                vecs[i].e_instr);
      chk("pc",          i, pc,                   vecs[i].e_pc);
      chk("misaligned",  i, {31'b0, misaligned},  {31'b0, vecs[i].e_mis});
    end

    // Streaming: always-granting memory answering one cycle after each grant,
    // consumer always ready; expect sequential PCs with instr = ~pc.
    got = 0; exp_pc = 32'h0; pend = 1'b0; pend_addr = '0;
    for (int cyc = 0; cyc < 60 && got < 4; cyc++) begin
      @(negedge clk);
      imem_gnt = 1'b1; instr_ready = 1'b1; redirect = 1'b0;
      imem_rvalid = pend; imem_rdata = ~pend_addr;
      #1;
      if (instr_valid) begin
        chk("stream_pc",    got, pc,    exp_pc);
        chk("stream_instr", got, instr, ~exp_pc);
        got++;
        exp_pc = exp_pc + 32'd4;
      end
      pend = imem_req;
      pend_addr = imem_addr;
    end
    chk("stream_count", 0, got, 32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/beta_fetch.md
BETA_FETCH -- requirements
Module: beta_fetch

Interface
REQ-001 Parameter BOOT_ADDR, default 32'h0000_0000, SHALL be the PC loaded at reset.
REQ-002 Parameter IBUF_DEPTH, default 2, SHALL be the number of instruction-buffer entries (fixed at 2 in this revision).
REQ-003 clk_i  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rstn_i  in  1  SHALL be the reset, asynchronous and active-low.
REQ-005 imem_req_o  out  1  SHALL be the instruction-memory request.
REQ-006 imem_addr_o  out  XLEN  SHALL be the word-aligned fetch address.
REQ-007 imem_gnt_i  in  1  SHALL be the request accepted (address phase done).
REQ-008 imem_rvalid_i  in  1  SHALL be the response valid.
REQ-009 imem_rdata_i  in  XLEN  SHALL be the response instruction word.
REQ-010 instr_o  out  XLEN  SHALL be the buffer-head instruction, driving the decoder instr_i.
REQ-011 pc_o  out  XLEN  SHALL be the PC of instr_o.
REQ-012 instr_valid_o  out  1  SHALL be high when instr_o/pc_o are valid.
REQ-013 instr_ready_i  in  1  SHALL be the consumer accept; pop on valid&ready.
REQ-014 redirect_i  in  1  SHALL be the branch/jump/exception redirect strobe.
REQ-015 redirect_pc_i  in  XLEN  SHALL be the redirect target.
REQ-016 fetch_misaligned_o  out  1  SHALL be the one-cycle misaligned-target pulse (see Configuration).

Function
REQ-017 FSM states SHALL be IDLE, REQ, WAIT, HALT.
REQ-018 IDLE SHALL go to REQ on the first clock after reset release.
REQ-019 In REQ, imem_req_o SHALL be 1 with imem_addr_o = pc_q only while occupancy + outstanding < 2; otherwise imem_req_o = 0 and the FSM stays in REQ.
REQ-020 On imem_req_o & imem_gnt_i, pc_q SHALL advance by 4 (mod 2^XLEN, wrapping silently) and the FSM SHALL go to WAIT with one outstanding request.
REQ-021 At most one request SHALL be outstanding; imem_req_o SHALL be 0 in WAIT.
REQ-022 In WAIT, on imem_rvalid_i, {fetched PC, imem_rdata_i} SHALL be pushed and the FSM SHALL return to REQ; the earliest instr_valid_o is the cycle after rvalid.
REQ-023 instr_valid_o SHALL equal buffer non-empty; instr_o/pc_o SHALL come from the head entry with no combinational path from imem_rdata_i.
REQ-024 Simultaneous push and pop SHALL be allowed at any occupancy, including full.
REQ-025 On redirect_i, the buffer SHALL be flushed, pc_q SHALL load redirect_pc_i and the FSM SHALL go to REQ the next cycle; a pop in the same cycle has no further effect.
REQ-026 A request outstanding at redirect, or granted in the redirect cycle, SHALL set discard_q; its rvalid SHALL be dropped, clear discard_q and not be pushed.
REQ-027 While discard_q = 1, no new request SHALL issue.
REQ-028 rvalid with no outstanding request SHALL be ignored.
REQ-029 HALT SHALL drive imem_req_o = 0 and instr_valid_o = 0, and exit only on a redirect_i with an aligned target.

Reset
REQ-030 On rstn_i low: pc_q = BOOT_ADDR, state IDLE, buffer empty, discard_q = 0, all outputs 0.
REQ-031 Reset asserted mid-transaction SHALL abandon it; responses after reset release without a new request SHALL be ignored.

Configuration
REQ-032 With BETA_FETCH_MISALIGN_CHECK_EN defined, a redirect with redirect_pc_i[1:0] != 0 SHALL pulse fetch_misaligned_o for 1 cycle, flush, not load pc_q, and enter HALT.
REQ-033 Without it, redirect_pc_i[1:0] SHALL be forced to 0 and fetch_misaligned_o SHALL be tied 0.

Structure
REQ-034 beta_pkg SHALL hold the fetch-state enum typedef, the ibuf entry struct {pc, instr}, and BOOT_ADDR_DEFAULT; XLEN comes from beta_pkg.
REQ-035 The 2-entry buffer SHALL be the sub-module beta_ibuf (push/pop/flush, full/empty, count).

Verification
REQ-036 Reset release, gnt=1 and rvalid one cycle later -> addresses 0x0, 0x4, 0x8; instr_valid_o first high 3 cycles after IDLE exit; pc_o = 0x0.
REQ-037 instr_ready_i = 0 -> exactly 2 entries buffered, imem_req_o = 0; a single ready pulse -> one pop and one new request.
REQ-038 Redirect to 0x100 while in WAIT -> stale rvalid dropped; next imem_addr_o = 0x100; first pc_o = 0x100.
REQ-039 Redirect to 0x102: with the macro -> fetch_misaligned_o 1-cycle pulse, HALT, no requests until redirect to 0x200; without it -> fetch from 0x100.
REQ-040 pc_q = 0xFFFF_FFFC granted -> next address 0x0000_0000.
REQ-041 rstn_i low during WAIT, rvalid after release -> ignored; first request to BOOT_ADDR.
